// File: rtl/hit_index_serializer_pkg.sv
// hit_pkg: shared definitions for the hit-index serializer slice.
//   WIDTH_DEF / IDX_W_DEF / CNT_W_DEF : default mask, index and counter widths
//   state_e                           : serializer FSM states
//   ALL_ONES_MASK                     : all-ones mask word at the default width
package hit_pkg;

  localparam int unsigned WIDTH_DEF = 64;
  localparam int unsigned IDX_W_DEF = 6;
  localparam int unsigned CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic [WIDTH_DEF-1:0] ALL_ONES_MASK = '1;

endpackage

// File: rtl/hit_index_serializer_if.sv
// hit_index_serializer_if: mask-in / index-out handshake bundle.
//   Input side : IN_VALID, IN_READY, IN_MASK
//   Output side: OUT_VALID, OUT_READY, OUT_INDEX, OUT_LAST, OUT_EMPTY, OUT_HEADER
//   Status     : HIT_COUNT, MASK_COUNT
//   master modport: the environment (mask source + index sink)
//   slave modport : the serializer
interface hit_index_serializer_if
  import hit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) ();

  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_MASK;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [IDX_W-1:0] OUT_INDEX;
  logic             OUT_LAST;
  logic             OUT_EMPTY;
  logic             OUT_HEADER;
  logic [CNT_W-1:0] HIT_COUNT;
  logic [CNT_W-1:0] MASK_COUNT;

  modport slave (
    input  IN_VALID, IN_MASK, OUT_READY,
    output IN_READY, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_EMPTY, OUT_HEADER,
           HIT_COUNT, MASK_COUNT
  );

  modport master (
    output IN_VALID, IN_MASK, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_INDEX, OUT_LAST, OUT_EMPTY, OUT_HEADER,
           HIT_COUNT, MASK_COUNT
  );

endinterface

// File: rtl/hit_index_serializer_lsb_priority_encoder.sv
// lsb_priority_encoder: combinational lowest-set-bit finder.
//   mask_i   : input word
//   index_o  : position of the lowest set bit (0 when mask_i is zero)
//   onehot_o : one-hot of that bit, used to clear it
//   zero_o   : mask_i has no bits set
//   single_o : mask_i has exactly one bit set
module lsb_priority_encoder
  import hit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF
) (
  input  logic [WIDTH-1:0] mask_i,
  output logic [IDX_W-1:0] index_o,
  output logic [WIDTH-1:0] onehot_o,
  output logic             zero_o,
  output logic             single_o
);

  logic [WIDTH-1:0] lowest;

  always_comb begin
    // Two's-complement trick isolates the lowest set bit.
    lowest   = mask_i & (~mask_i + WIDTH'(1));
    onehot_o = lowest;
    zero_o   = (mask_i == '0);
    single_o = (mask_i != '0) && ((mask_i & (mask_i - WIDTH'(1))) == '0);
    index_o  = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (lowest[i]) begin
        index_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/hit_index_serializer.sv
// hit_index_serializer: expands a hit mask into the indices of its set bits,
// LSB first, one index per output handshake; publishes hit and mask counts.
//   CNT_CLK : clock
//   CNT_RST : asynchronous active-high reset
//   bus     : hit_index_serializer_if.slave (mask in, index beats out, counts)
// Optional build macro HIT_INDEX_HEADER_EN: emit a frame-start header beat
// before the indices of each mask.
module hit_index_serializer
  import hit_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned IDX_W = IDX_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input logic                   CNT_CLK,
  input logic                   CNT_RST,
  hit_index_serializer_if.slave bus
);

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [IDX_W-1:0] out_index_q;
  logic             out_last_q;
  logic             out_empty_q;
  logic [WIDTH-1:0] remain_q;
  logic [WIDTH-1:0] onehot_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] hit_count_q;
  logic [CNT_W-1:0] mask_count_q;
`ifdef HIT_INDEX_HEADER_EN
  logic             out_header_q;
`endif

  logic [WIDTH-1:0] enc_src;
  logic [IDX_W-1:0] enc_index;
  logic [WIDTH-1:0] enc_onehot;
  logic             enc_zero;
  logic             enc_single;

  // The encoder looks one beat ahead so every output can be registered:
  // in IDLE it sees the incoming mask, in HEADER the stored mask, and in
  // SCAN the stored mask with the currently presented bit already cleared.
  always_comb begin
    enc_src = remain_q & ~onehot_q;
    case (state_q)
      ST_IDLE:   enc_src = bus.IN_MASK;
      ST_HEADER: enc_src = remain_q;
      default:   enc_src = remain_q & ~onehot_q;
    endcase
  end

  lsb_priority_encoder #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_enc (
    .mask_i   (enc_src),
    .index_o  (enc_index),
    .onehot_o (enc_onehot),
    .zero_o   (enc_zero),
    .single_o (enc_single)
  );

  always_ff @(posedge CNT_CLK or posedge CNT_RST) begin
    if (CNT_RST) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_index_q  <= '0;
      out_last_q   <= 1'b0;
      out_empty_q  <= 1'b0;
      remain_q     <= '0;
      onehot_q     <= '0;
      beat_cnt_q   <= '0;
      hit_count_q  <= '0;
      mask_count_q <= '0;
`ifdef HIT_INDEX_HEADER_EN
      out_header_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_ready_q && bus.IN_VALID) begin
            remain_q    <= bus.IN_MASK;
            beat_cnt_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
`ifdef HIT_INDEX_HEADER_EN
            state_q      <= ST_HEADER;
            out_header_q <= 1'b1;
            out_index_q  <= '0;
            out_last_q   <= 1'b0;
            out_empty_q  <= 1'b0;
`else
            state_q     <= ST_SCAN;
            onehot_q    <= enc_onehot;
            out_index_q <= enc_index;
            out_last_q  <= enc_single | enc_zero;
            out_empty_q <= enc_zero;
`endif
          end
        end

`ifdef HIT_INDEX_HEADER_EN
        ST_HEADER: begin
          if (bus.OUT_READY) begin
            state_q      <= ST_SCAN;
            out_header_q <= 1'b0;
            onehot_q     <= enc_onehot;
            out_index_q  <= enc_index;
            out_last_q   <= enc_single | enc_zero;
            out_empty_q  <= enc_zero;
          end
        end
`endif

        ST_SCAN: begin
          if (bus.OUT_READY) begin
            if (out_last_q) begin
              hit_count_q  <= out_empty_q ? '0 : beat_cnt_q + CNT_W'(1);
              mask_count_q <= mask_count_q + CNT_W'(1);
              state_q      <= ST_IDLE;
              in_ready_q   <= 1'b1;
              out_valid_q  <= 1'b0;
              out_index_q  <= '0;
              out_last_q   <= 1'b0;
              out_empty_q  <= 1'b0;
              remain_q     <= '0;
              onehot_q     <= '0;
            end else begin
              remain_q    <= remain_q & ~onehot_q;
              beat_cnt_q  <= beat_cnt_q + CNT_W'(1);
              onehot_q    <= enc_onehot;
              out_index_q <= enc_index;
              out_last_q  <= enc_single;
              out_empty_q <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.IN_READY   = in_ready_q;
  assign bus.OUT_VALID  = out_valid_q;
  assign bus.OUT_INDEX  = out_index_q;
  assign bus.OUT_LAST   = out_last_q;
  assign bus.OUT_EMPTY  = out_empty_q;
  assign bus.HIT_COUNT  = hit_count_q;
  assign bus.MASK_COUNT = mask_count_q;
`ifdef HIT_INDEX_HEADER_EN
  assign bus.OUT_HEADER = out_header_q;
`else
  assign bus.OUT_HEADER = 1'b0;
`endif

endmodule

// File: tb/tb_hit_index_serializer.sv
// Testbench for hit_index_serializer: directed masks from the test plan plus
// randomized masks, checked by a queue scoreboard fed from a reference model.
module tb_hit_index_serializer;
  import hit_pkg::*;

  localparam int unsigned W  = 64;
  localparam int unsigned IW = 6;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic          last;
    logic          empty;
    logic          header;
  } beat_t;

  typedef struct packed {
    logic [CW-1:0] hit;
    logic [CW-1:0] masks;
  } cnt_t;

  logic clk = 1'b0;
  logic rst;

  hit_index_serializer_if #(.WIDTH(W), .IDX_W(IW), .CNT_W(CW)) bus ();

  hit_index_serializer #(.WIDTH(W), .IDX_W(IW), .CNT_W(CW)) dut (
    .CNT_CLK (clk),
    .CNT_RST (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  beat_t       exp_q[$];
  cnt_t        cnt_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;
  int          hs_count = 0;
  int unsigned last_hs_cyc = 0;
  int unsigned accept_cyc  = 0;
  bit          mon_en = 1'b0;
  bit          cnt_pending = 1'b0;
  bit          prev_stall = 1'b0;
  int          model_masks = 0;
  int          rdy_mode = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of set positions, ascending, from the mask.
  task automatic model_push(input logic [63:0] m);
    int    pos[$];
    beat_t b;
    cnt_t  c;
`ifdef HIT_INDEX_HEADER_EN
    b = '{idx: '0, last: 1'b0, empty: 1'b0, header: 1'b1};
    exp_q.push_back(b);
`endif
    for (int i = 0; i < 64; i++) if (m[i]) pos.push_back(i);
    if (pos.size() == 0) begin
      b = '{idx: '0, last: 1'b1, empty: 1'b1, header: 1'b0};
      exp_q.push_back(b);
    end else begin
      for (int k = 0; k < pos.size(); k++) begin
        b = '{idx: IW'(pos[k]), last: (k == pos.size() - 1), empty: 1'b0, header: 1'b0};
        exp_q.push_back(b);
      end
    end
    model_masks++;
    c.hit   = CW'(pos.size());
    c.masks = CW'(model_masks);
    cnt_q.push_back(c);
  endtask

  // OUT_READY driver.
  initial begin
    bus.OUT_READY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.OUT_READY = 1'b1;
        1:       bus.OUT_READY = ~bus.OUT_READY;
        default: bus.OUT_READY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare presented beats with the scoreboard head; counts are
  // checked one cycle after a final handshake.
  always @(negedge clk) begin
    beat_t act;
    cnt_t  ec;
    if (mon_en && !rst) begin
      if (cnt_pending) begin
        cnt_pending = 1'b0;
        if (cnt_q.size() == 0) begin
          check("count_queue_empty", 64'(cnt_q.size()), 64'd1);
        end else begin
          ec = cnt_q.pop_front();
          check("hit_count", 64'(bus.HIT_COUNT), 64'(ec.hit));
          check("mask_count", 64'(bus.MASK_COUNT), 64'(ec.masks));
        end
      end
      if (bus.OUT_VALID) begin
        act = '{idx: bus.OUT_INDEX, last: bus.OUT_LAST, empty: bus.OUT_EMPTY,
                header: bus.OUT_HEADER};
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(bus.OUT_VALID), 64'd0);
        end else begin
          check("beat{idx,last,empty,hdr}", 64'(act), 64'(exp_q[0]));
          if (bus.OUT_READY) begin
            void'(exp_q.pop_front());
            hs_count++;
            if (act.last) begin
              cnt_pending = 1'b1;
              last_hs_cyc = cyc + 1;
            end
          end
        end
      end else if (prev_stall) begin
        check("valid_dropped_under_stall", 64'(bus.OUT_VALID), 64'd1);
      end
      prev_stall = bus.OUT_VALID && !bus.OUT_READY;
    end
  end

  task automatic send_mask(input logic [63:0] m);
    bit got;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b1;
    bus.IN_MASK  = m;
    model_push(m);
    got = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk);
      if (bus.IN_READY) got = 1'b1;
    end
    if (!got) begin
      check("accept_timeout", 64'(got), 64'd1);
      bus.IN_VALID = 1'b0;
      return;
    end
    accept_cyc = cyc + 1;
    @(posedge clk);
    #1;
    bus.IN_VALID = 1'b0;
    bus.IN_MASK  = {$urandom, $urandom};
    @(negedge clk);
    check("first_beat_latency", 64'(bus.OUT_VALID), 64'd1);
    check("in_ready_while_busy", 64'(bus.IN_READY), 64'd0);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 5000 && !done; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && cnt_q.size() == 0 && !cnt_pending) done = 1'b1;
    end
    check("drain_pending_beats", 64'(exp_q.size() + cnt_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},   64'(bus.IN_READY),   64'd0);
    check({tag, "_out_valid"},  64'(bus.OUT_VALID),  64'd0);
    check({tag, "_out_index"},  64'(bus.OUT_INDEX),  64'd0);
    check({tag, "_out_last"},   64'(bus.OUT_LAST),   64'd0);
    check({tag, "_out_empty"},  64'(bus.OUT_EMPTY),  64'd0);
    check({tag, "_out_header"}, 64'(bus.OUT_HEADER), 64'd0);
    check({tag, "_hit_count"},  64'(bus.HIT_COUNT),  64'd0);
    check({tag, "_mask_count"}, 64'(bus.MASK_COUNT), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m;
    int          base;
    bit          reached;

    rst          = 1'b1;
    bus.IN_VALID = 1'b0;
    bus.IN_MASK  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_before_first_edge", 64'(bus.IN_READY), 64'd0);
    @(negedge clk);
    check("ready_after_first_edge", 64'(bus.IN_READY), 64'd1);
    mon_en = 1'b1;

    // Directed masks
    rdy_mode = 0;
    send_mask(64'h0000_0000_0000_0013);
    drain();
    send_mask(64'h0);
    drain();
    send_mask(64'h6);
    drain();

    rdy_mode = 1;
    m = ALL_ONES_MASK;
    send_mask(m);
    drain();

    rdy_mode = 0;
    send_mask(64'h8000_0000_0000_0001);
    send_mask(64'h0000_0000_0000_0400);
    check("idle_gap_between_masks", 64'(accept_cyc - last_hs_cyc), 64'd1);
    drain();

    // Reset in the middle of a frame
    base = hs_count;
    send_mask(64'h1F);
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      if (hs_count - base >= 2) reached = 1'b1;
      else @(negedge clk);
    end
    check("midframe_two_beats_seen", 64'(reached), 64'd1);
    @(posedge clk);
    mon_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midframe_reset");
    exp_q.delete();
    cnt_q.delete();
    cnt_pending = 1'b0;
    prev_stall  = 1'b0;
    model_masks = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_midframe_reset", 64'(bus.IN_READY), 64'd1);
    check("hit_count_after_midframe_reset", 64'(bus.HIT_COUNT), 64'd0);
    mon_en = 1'b1;
    send_mask(64'h2);
    drain();

    // Randomized masks with random backpressure
    for (int n = 0; n < 40; n++) begin
      rdy_mode = (n % 3 == 0) ? 1 : 2;
      case ($urandom_range(0, 5))
        0:       m = {$urandom, $urandom};
        1:       m = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2:       m = 64'h0;
        3:       m = 64'h1 << $urandom_range(0, 63);
        4:       m = (64'h1 << 63) | 64'($urandom_range(0, 15));
        default: m = ~(64'h1 << $urandom_range(0, 63));
      endcase
      send_mask(m);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
